morse_encoder: RTL and testbench

- Morse transmitter; the send-side counterpart of the team's Morse decoder datapath.
- Accepts one character per request as an element count plus a dot/dash pattern, and drives a keyed on/off line using standard ITU unit timing.
- Unit length is derived internally from in_clk by a prescale counter.
- Sits between a character-to-pattern lookup and the LED/buzzer key driver.

---
 rtl/morse_encoder.sv | 144 ++++++++++++++
 tb/tb_morse_encoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse transmitter: turns an element count plus dot/dash pattern into a keyed
// on/off line using ITU unit timing derived from an internal prescaler.
module morse_encoder #(
    parameter int UNIT_CYCLES = 10,
    parameter int MAX_LEN     = 5
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sym_len,
    input  logic [4:0] sym_pat,
    output logic       key_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

    localparam int            PW         = $clog2(UNIT_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);
    localparam logic [2:0]    LEN_MAX    = 3'(MAX_LEN);

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    units_reg, units_next;
    logic [2:0]    idx_reg, idx_next;
    logic [4:0]    pat_reg, pat_next;
    logic          key_reg, key_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          tick;
    logic          seg_end;
    logic [2:0]    len_eff;
    logic [2:0]    idx_prev;

    function automatic logic [2:0] elem_units(input logic dash);
        return dash ? 3'd3 : 3'd1;
    endfunction

    assign tick    = (state_reg != IDLE) && (presc_reg == PRESC_LAST);
    assign seg_end = tick && (units_reg == 3'd1);

    always_comb begin
        state_next = state_reg;
        units_next = units_reg;
        idx_next   = idx_reg;
        pat_next   = pat_reg;
        key_next   = key_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        len_eff    = (sym_len > LEN_MAX) ? LEN_MAX : sym_len;
        idx_prev   = idx_reg - 3'd1;

        // Prescaler idles at zero, so acceptance always starts a fresh unit.
        if ((state_reg == IDLE) || (presc_reg == PRESC_LAST))
            presc_next = '0;
        else
            presc_next = presc_reg + PW'(1);

        if (tick)
            units_next = units_reg - 3'd1;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    pat_next  = sym_pat;
                    busy_next = 1'b1;
                    if (len_eff == 3'd0) begin
                        state_next = LGAP;
                        units_next = 3'd4;
                        idx_next   = 3'd0;
                        key_next   = 1'b0;
                    end else begin
                        state_next = MARK;
                        idx_next   = len_eff - 3'd1;
                        units_next = elem_units(sym_pat[len_eff - 3'd1]);
                        key_next   = 1'b1;
                    end
                end
            end
            MARK: begin
                if (seg_end) begin
                    key_next = 1'b0;
                    if (idx_reg == 3'd0) begin
                        state_next = LGAP;
                        units_next = 3'd3;
                    end else begin
                        state_next = GAP;
                        units_next = 3'd1;
                    end
                end
            end
            GAP: begin
                if (seg_end) begin
                    state_next = MARK;
                    idx_next   = idx_prev;
                    units_next = elem_units(pat_reg[idx_prev]);
                    key_next   = 1'b1;
                end
            end
            LGAP: begin
                if (seg_end) begin
                    state_next = IDLE;
                    units_next = 3'd0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                key_next   = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            units_reg <= 3'd0;
            idx_reg   <= 3'd0;
            pat_reg   <= 5'd0;
            key_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            units_reg <= units_next;
            idx_reg   <= idx_next;
            pat_reg   <= pat_next;
            key_reg   <= key_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign key_out = key_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4: compares key_out traces
// and busy/done timing against traces built from the Morse timing rules.
module tb_morse_encoder;

    localparam int U = 4;

    logic       in_clk;
    logic       rst;
    logic       start;
    logic [2:0] sym_len;
    logic [4:0] sym_pat;
    logic       key_out;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    morse_encoder #(.UNIT_CYCLES(U), .MAX_LEN(5)) dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .start   (start),
        .sym_len (sym_len),
        .sym_pat (sym_pat),
        .key_out (key_out),
        .busy    (busy),
        .done    (done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the DUT idle or in its done cycle. With hold=1
    // start stays high for the whole character; otherwise it is dropped after
    // acceptance and two stray start pulses are thrown in mid-character.
    task automatic run_char(input string name, input logic [2:0] len,
                            input logic [4:0] pat, input bit hold);
        bit exp_tr[$];
        int n_busy, n_bad, eff;
        exp_tr.delete();
        eff = (len > 3'd5) ? 5 : int'(len);
        if (eff == 0) begin
            for (int k = 0; k < 4*U; k++) exp_tr.push_back(1'b0);
        end else begin
            for (int i = eff - 1; i >= 0; i--) begin
                for (int k = 0; k < (pat[i] ? 3 : 1)*U; k++) exp_tr.push_back(1'b1);
                if (i > 0)
                    for (int k = 0; k < U; k++) exp_tr.push_back(1'b0);
            end
            for (int k = 0; k < 3*U; k++) exp_tr.push_back(1'b0);
        end

        sym_len = len;
        sym_pat = pat;
        start   = 1'b1;
        n_busy  = 0;
        n_bad   = 0;
        @(posedge in_clk);
        for (int c = 0; c < 400; c++) begin
            @(negedge in_clk);
            if (!hold) begin
                start = (c == 5) || (c == 9);
                if (c == 5) begin
                    sym_len = 3'd5;
                    sym_pat = ~pat;
                end
            end
            if (busy !== 1'b1) break;
            if (n_busy < exp_tr.size()) begin
                if (key_out !== exp_tr[n_busy]) n_bad++;
            end
            if (done !== 1'b0) n_bad++;
            n_busy++;
        end
        $display("[TB] %s len=%0d pat=%b busy_cycles=%0d trace_errs=%0d",
                 name, len, pat, n_busy, n_bad);
        check({name, "_busy_cycles"}, n_busy, exp_tr.size());
        check({name, "_trace"}, n_bad, 0);
        check({name, "_done_pulse"}, done, 1'b1);
        check({name, "_key_after"}, key_out, 1'b0);
        if (!hold) begin
            @(negedge in_clk);
            check({name, "_done_drop"}, done, 1'b0);
            check({name, "_stay_idle"}, busy, 1'b0);
        end
    endtask

    initial begin
        int bad;
        rst     = 1'b1;
        start   = 1'b0;
        sym_len = 3'd0;
        sym_pat = 5'd0;
        #1;
        check("rst_key", key_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (3) @(negedge in_clk);
        rst = 1'b0;

        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge in_clk);
            if (key_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_50", bad, 0);

        // Hand-computed busy lengths: A=32, 0=88, word space=16.
        run_char("A", 3'd2, 5'b00001, 1'b0);
        run_char("zero", 3'd5, 5'b11111, 1'b0);
        run_char("word", 3'd0, 5'b10101, 1'b0);
        run_char("clamp", 3'd7, 5'b01001, 1'b0);

        // Start held high: second E accepted in the done cycle of the first.
        run_char("E_hold", 3'd1, 5'b00000, 1'b1);
        run_char("E_b2b", 3'd1, 5'b00000, 1'b0);

        // Reset 10 cycles into the dash of 'A'.
        sym_len = 3'd2;
        sym_pat = 5'b00001;
        start   = 1'b1;
        @(posedge in_clk);
        for (int c = 0; c <= 18; c++) begin
            @(negedge in_clk);
            start = 1'b0;
        end
        check("pre_rst_key", key_out, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_key", key_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge in_clk);
            if (done !== 1'b0 || key_out !== 1'b0) bad++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge in_clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_no_done", bad, 0);
        run_char("A_after_rst", 3'd2, 5'b00001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
